// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian byte stream (word count, instruction
// words, XOR checksum) and writes the words to instruction memory at
// consecutive word addresses starting at 0. The CPU is held in reset until
// a load finishes with a matching checksum.
module imem_loader #(
  parameter int MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  // The word index only has to reach MEM_SIZE-1, so it is sized for that.
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [16:0] MAX_N = 17'(MEM_SIZE);

  state_t             state;
  logic [15:0]        count;
  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         byte_idx;
  logic [7:0]         chk;
  logic [23:0]        word_part;
  logic               xfer;
  logic [15:0]        n_new;
  logic [15:0]        last_idx;

  assign xfer     = in_valid && in_ready;
  assign n_new    = {count[15:8], in_data};
  assign last_idx = count - 16'd1;

  // Loader FSM: every output is registered and updated together with the
  // state, so in_ready/done/error/cpu_hold always match the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      chk       <= '0;
      word_part <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR_HI;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
            if (n_new == 16'd0 || {1'b0, n_new} > MAX_N) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state    <= DATA;
              word_idx <= '0;
              byte_idx <= '0;
              chk      <= '0;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            word_part <= {word_part[15:0], in_data};
            chk       <= chk ^ in_data;
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= 32'(word_idx) << 2;
              mem_wdata <= {word_part, in_data};
              if (16'(word_idx) == last_idx) begin
                state <= CHK;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
        end
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives byte streams into imem_loader and checks every
// memory write against a scoreboard of expected (address, word) pairs,
// plus the done/error/cpu_hold results of each session.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int totalCount = 0;
   int badCount   = 0;

   logic [63:0] expQ[$];
   logic [31:0] wordsBuf[$];

   imem_loader #(.MEM_SIZE(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something blocks forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (actual=running required=finished)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
      end
   endtask

   // Every write strobe seen must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_we", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            checkOutput("write_addr", {32'd0, mem_addr}, {32'd0, e[63:32]});
            checkOutput("write_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gaps, input bit startNoise);
      bit got;
      int budget;
      got = 1'b0;
      budget = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            if (startNoise && $urandom_range(0, 1) == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!got && budget < 50) begin
         @(negedge clk);
         if (in_ready === 1'b1) got = 1'b1;
         @(posedge clk); #1;
         budget++;
      end
      in_valid = 1'b0;
      if (!got) checkOutput("ready_timeout", 64'd0, 64'd1);
   endtask

   // Runs one session with words taken from wordsBuf. stopAfter >= 0 ends
   // the stream after that many data bytes.
   task automatic applyStimulus(input int n, input bit badChk, input bit gaps,
                                input bit startNoise, input int stopAfter);
      logic [7:0]  chkVal;
      logic [7:0]  b;
      logic [31:0] w;
      logic [15:0] n16;
      int sent;
      n16 = 16'(n);
      pulseStart();
      checkOutput("start_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("start_hold",  {63'd0, cpu_hold}, 64'd1);
      checkOutput("start_done",  {63'd0, done},     64'd0);
      checkOutput("start_error", {63'd0, error},    64'd0);
      sendByte(n16[15:8], gaps, 1'b0);
      sendByte(n16[7:0],  gaps, 1'b0);
      if (n == 0 || n > 256) return;
      chkVal = 8'h00;
      sent = 0;
      for (int k = 0; k < n; k++) begin
         w = wordsBuf[k];
         for (int j = 0; j < 4; j++) begin
            if (stopAfter >= 0 && sent == stopAfter) return;
            b = w[31 - 8*j -: 8];
            chkVal ^= b;
            if (j == 3) expQ.push_back({32'(k) << 2, w});
            sendByte(b, gaps, startNoise);
            sent++;
         end
      end
      sendByte(badChk ? (chkVal ^ 8'h01) : chkVal, gaps, 1'b0);
   endtask

   task automatic waitEnd(input bit expDone, input bit expErr);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1 || error === 1'b1) seen = 1'b1;
      end
      if (!seen) checkOutput("end_timeout", 64'd0, 64'd1);
      checkOutput("end_done",  {63'd0, done},     {63'd0, expDone});
      checkOutput("end_error", {63'd0, error},    {63'd0, expErr});
      checkOutput("end_hold",  {63'd0, cpu_hold}, {63'd0, !expDone});
      checkOutput("end_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("pending_writes", 64'(expQ.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic loadWords(input int n, input bit useRandom);
      wordsBuf.delete();
      for (int i = 0; i < n; i++) wordsBuf.push_back(useRandom ? $urandom() : 32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;

      // Reset with start and a valid byte present: reset must win.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("rst_we",    {63'd0, mem_we},   64'd0);
      checkOutput("rst_addr",  {32'd0, mem_addr}, 64'd0);
      checkOutput("rst_wdata", {32'd0, mem_wdata}, 64'd0);
      checkOutput("rst_done",  {63'd0, done},     64'd0);
      checkOutput("rst_error", {63'd0, error},    64'd0);
      checkOutput("rst_hold",  {63'd0, cpu_hold}, 64'd1);
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;

      // Idle with in_valid high: nothing is accepted.
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle_ready", {63'd0, in_ready}, 64'd0);
         checkOutput("idle_hold",  {63'd0, cpu_hold}, 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;

      // N=2 example program, good checksum.
      wordsBuf.delete();
      wordsBuf.push_back(32'h2008_0005);
      wordsBuf.push_back(32'hAC09_0004);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b1, 1'b0);

      // Same program, corrupted checksum: words still written, then error.
      applyStimulus(2, 1'b1, 1'b0, 1'b0, -1);
      waitEnd(1'b0, 1'b1);

      // Illegal counts.
      applyStimulus(0, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b0, 1'b1);
      applyStimulus(257, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b0, 1'b1);

      // Full memory: last write lands at 0x3FC.
      loadWords(256, 1'b1);
      applyStimulus(256, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b1, 1'b0);

      // N=3 with random in_valid gaps and stray start pulses in DATA.
      loadWords(3, 1'b1);
      applyStimulus(3, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b1, 1'b0);
      applyStimulus(3, 1'b0, 1'b1, 1'b1, -1);
      waitEnd(1'b1, 1'b0);

      // Reset after five data bytes, then a fresh N=1 load.
      loadWords(2, 1'b1);
      applyStimulus(2, 1'b0, 1'b0, 1'b0, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("midrst_hold",  {63'd0, cpu_hold}, 64'd1);
      checkOutput("midrst_done",  {63'd0, done},     64'd0);
      checkOutput("midrst_pending", 64'(expQ.size()), 64'd0);
      @(posedge clk); #1;
      wordsBuf.delete();
      wordsBuf.push_back(32'h1234_5678);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, -1);
      waitEnd(1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
